envelope_avg: RTL and testbench

- Moving-average low-pass stage placed directly downstream of the full-bridge rectifier in the demodulator path.
- Takes the rectifier's 12-bit magnitude samples and averages them over a power-of-two window to recover the AM envelope.
- Uses a circular sample buffer and a running sum. Output feeds the demod decision/threshold logic.

---
 rtl/envelope_avg.sv | 99 +++++++++
 tb/tb_envelope_avg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/envelope_avg.sv
// Moving-average envelope filter: running sum over a power-of-two circular window.
// Optional macro ENVELOPE_AVG_DECIM_EN emits one block average per window instead of a sliding one.
module envelope_avg #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned LOG2_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              filled
);

  localparam int unsigned N     = 1 << LOG2_N;
  localparam int unsigned SUM_W = DATA_W + LOG2_N;
  localparam logic [LOG2_N-1:0] LAST = '1;

  typedef enum logic {StFill, StRun} state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  sample_q [N];
  logic [SUM_W-1:0]   sum_q;
  logic [LOG2_N-1:0]  wr_ptr_q;
  logic [LOG2_N-1:0]  fill_cnt_q;

  logic [SUM_W-1:0]   sum_d;
  logic [DATA_W-1:0]  avg;
  logic               phase_hit;
  logic               strobe;

`ifdef ENVELOPE_AVG_DECIM_EN
  logic [LOG2_N-1:0]  phase_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
    end else if (clear) begin
      phase_q <= '0;
    end else if (in_valid) begin
      phase_q <= phase_q + 1'b1;
    end
  end

  // Only the sample that completes a window produces a block average.
  assign phase_hit = (phase_q == LAST);
`else
  assign phase_hit = 1'b1;
`endif

  always_comb begin
    sum_d  = sum_q + SUM_W'(in_data) - SUM_W'(sample_q[wr_ptr_q]);
    avg    = sum_d[SUM_W-1:LOG2_N];
    // The Nth fill sample already yields a valid average.
    strobe = ((state_q == StRun) || (fill_cnt_q == LAST)) && phase_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) sample_q[i] <= '0;
      sum_q      <= '0;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      state_q    <= StFill;
      out_valid  <= 1'b0;
      out_data   <= '0;
      filled     <= 1'b0;
    end else if (clear) begin
      for (int unsigned i = 0; i < N; i++) sample_q[i] <= '0;
      sum_q      <= '0;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      state_q    <= StFill;
      out_valid  <= 1'b0;
      filled     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        sample_q[wr_ptr_q] <= in_data;
        sum_q              <= sum_d;
        wr_ptr_q           <= wr_ptr_q + 1'b1;
        if (state_q == StFill) begin
          fill_cnt_q <= fill_cnt_q + 1'b1;
          if (fill_cnt_q == LAST) begin
            state_q <= StRun;
            filled  <= 1'b1;
          end
        end
        if (strobe) begin
          out_valid <= 1'b1;
          out_data  <= avg;
        end
      end
    end
  end

endmodule

// File: tb/tb_envelope_avg.sv
// Directed bench for envelope_avg (N=16): fill, step, full scale, gaps, clear, reset, ramp.
module tb_envelope_avg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        out_valid;
  logic [11:0] out_data;
  logic        filled;

  int total = 0;
  int bad   = 0;

`ifdef ENVELOPE_AVG_DECIM_EN
  localparam bit DECIM = 1'b1;
`else
  localparam bit DECIM = 1'b0;
`endif

  envelope_avg #(.DATA_W(12), .LOG2_N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .filled    (filled)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; on return, outputs reflect that cycle.
  task automatic cyc(input logic v, input logic [11:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    int strobes;
    logic exp_strobe;

    // Reset state
    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_filled", 32'(filled), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Constant fill with 100
    strobes = 0;
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b1, 12'd100, 1'b0);
      strobes += int'(out_valid);
    end
    check("fill_no_strobe", 32'(strobes), 0);
    check("fill_not_filled", 32'(filled), 0);
    cyc(1'b1, 12'd100, 1'b0);
    check("fill16_valid", 32'(out_valid), 1);
    check("fill16_data", 32'(out_data), 100);
    check("fill16_filled", 32'(filled), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 12'd100, 1'b0);
      check("const_valid", 32'(out_valid), 1);
      check("const_data", 32'(out_data), 100);
    end
    cyc(1'b0, 12'd0, 1'b0);
    check("idle_no_strobe", 32'(out_valid), 0);
    check("idle_hold", 32'(out_data), 100);

    // Step response: fill with 0, step to 1600, back to 0
    cyc(1'b0, 12'd0, 1'b1);
    check("clr_filled", 32'(filled), 0);
    check("clr_valid", 32'(out_valid), 0);
    check("clr_hold", 32'(out_data), 100);
    for (int i = 0; i < 16; i++) cyc(1'b1, 12'd0, 1'b0);
    check("zero_fill_data", 32'(out_data), 0);
    for (int j = 1; j <= 18; j++) begin
      cyc(1'b1, 12'd1600, 1'b0);
      check("step_up", 32'(out_data), 32'((j > 16 ? 16 : j) * 100));
    end
    for (int j = 1; j <= 16; j++) begin
      cyc(1'b1, 12'd0, 1'b0);
      check("step_down", 32'(out_data), 32'(1600 - 100 * j));
    end

    // Full scale: no wrap, then one zero
    cyc(1'b0, 12'd0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 12'd4095, 1'b0);
      if (i >= 16) check("full_scale", 32'(out_data), 4095);
    end
    cyc(1'b1, 12'd0, 1'b0);
    check("full_drop_valid", 32'(out_valid), 1);
    check("full_drop_data", 32'(out_data), 3839);

    // Gapped input: one sample every third clock
    cyc(1'b0, 12'd0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 12'd48, 1'b0);
      check("gap_sample_valid", 32'(out_valid), 32'(i == 16));
      check("gap_sample_data", 32'(out_data), (i == 16) ? 48 : 3839);
      for (int g = 0; g < 2; g++) begin
        cyc(1'b0, 12'd0, 1'b0);
        check("gap_idle_valid", 32'(out_valid), 0);
        check("gap_idle_data", 32'(out_data), (i == 16) ? 48 : 3839);
      end
    end

    // Clear with simultaneous sample: sample dropped, refill needed
    cyc(1'b1, 12'd900, 1'b1);
    check("clrin_filled", 32'(filled), 0);
    check("clrin_valid", 32'(out_valid), 0);
    check("clrin_hold", 32'(out_data), 48);
    strobes = 0;
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b1, 12'd200, 1'b0);
      strobes += int'(out_valid);
    end
    check("clrin_no_strobe", 32'(strobes), 0);
    cyc(1'b1, 12'd200, 1'b0);
    check("clrin16_valid", 32'(out_valid), 1);
    check("clrin16_data", 32'(out_data), 200);

    // Asynchronous reset between edges while a strobe is showing
    cyc(1'b1, 12'd500, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_data", 32'(out_data), 0);
    check("arst_filled", 32'(filled), 0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 32'(out_valid), 0);
    strobes = 0;
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b1, 12'd64, 1'b0);
      strobes += int'(out_valid);
    end
    check("rst_refill_no_strobe", 32'(strobes), 0);
    cyc(1'b1, 12'd64, 1'b0);
    check("rst_refill_valid", 32'(out_valid), 1);
    check("rst_refill_data", 32'(out_data), 64);

    // Ramp 0..47: sliding average, or block average when decimating
    cyc(1'b0, 12'd0, 1'b1);
    strobes = 0;
    for (int k = 0; k < 48; k++) begin
      cyc(1'b1, 12'(k), 1'b0);
      exp_strobe = (k >= 15) && (!DECIM || (k % 16 == 15));
      strobes += int'(out_valid);
      check("ramp_valid", 32'(out_valid), 32'(exp_strobe));
      if (exp_strobe) check("ramp_data", 32'(out_data), 32'(k - 8));
    end
    check("ramp_strobes", 32'(strobes), DECIM ? 3 : 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
